// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stall/bubble, CP0 flush and the HI/LO busy counter.
// Optional PIPE_PERF_CNT_EN adds stall_cycles and req_count counters.
// Latency: stall/Req combinational; md_cnt/md_busy registered. No backpressure beyond stall.
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_rs_tuse,
   input  logic [1:0] D_rt_tuse,
   input  logic       D_is_md,
   input  logic       D_eret,
   input  logic [4:0] E_A3,
   input  logic       E_RegWrite,
   input  logic [1:0] E_tnew,
   input  logic [4:0] M_A3,
   input  logic       M_RegWrite,
   input  logic [1:0] M_tnew,
   input  logic       E_mtc0_epc,
   input  logic       M_mtc0_epc,
   input  logic       E_md_start,
   input  logic       E_md_div,
   input  logic       exc_req,
   output logic       stall,
   output logic       md_busy,
   output logic       Req,
   output logic [3:0] md_cnt
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] req_count
`endif
);

   localparam logic [3:0] LP_MULT_LEN = 4'(MULT_CYCLES);
   localparam logic [3:0] LP_DIV_LEN  = 4'(DIV_CYCLES);

   logic [3:0] r_md_cnt;
   logic       r_md_busy;
   logic [3:0] w_md_cnt_nxt;
   logic       w_rs_haz;
   logic       w_rt_haz;
   logic       w_md_haz;
   logic       w_eret_haz;
   logic       w_stall;

   // A producer only hazards when its result arrives later than the consumer needs it.
   assign w_rs_haz = (D_rs != 5'd0) &&
                     ((E_RegWrite && (E_A3 == D_rs) && (D_rs_tuse < E_tnew)) ||
                      (M_RegWrite && (M_A3 == D_rs) && (D_rs_tuse < M_tnew)));

   assign w_rt_haz = (D_rt != 5'd0) &&
                     ((E_RegWrite && (E_A3 == D_rt) && (D_rt_tuse < E_tnew)) ||
                      (M_RegWrite && (M_A3 == D_rt) && (D_rt_tuse < M_tnew)));

   assign w_md_haz   = D_is_md && (r_md_busy || E_md_start);
   assign w_eret_haz = D_eret && (E_mtc0_epc || M_mtc0_epc);

   // Flush wins over stall.
   assign w_stall = (w_rs_haz || w_rt_haz || w_md_haz || w_eret_haz) && !exc_req;

   always_comb begin
      w_md_cnt_nxt = r_md_cnt;
      if (E_md_start && !exc_req) begin
         w_md_cnt_nxt = E_md_div ? LP_DIV_LEN : LP_MULT_LEN;
      end else if (r_md_cnt != 4'd0) begin
         w_md_cnt_nxt = r_md_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_md_cnt  <= 4'd0;
         r_md_busy <= 1'b0;
      end else begin
         r_md_cnt  <= w_md_cnt_nxt;
         r_md_busy <= (w_md_cnt_nxt != 4'd0);
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_req_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= 32'd0;
         r_req_count    <= 32'd0;
      end else begin
         if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
         if (exc_req) r_req_count    <= r_req_count + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign req_count    = r_req_count;
`endif

   assign stall   = w_stall;
   assign Req     = exc_req;
   assign md_busy = r_md_busy;
   assign md_cnt  = r_md_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (F/D, D/E, E/M, M/W).
- Decides each cycle whether the front end stalls, whether the D/E register takes a bubble, and whether the whole pipeline is flushed to the handler on a CP0 request.
- Owns the multiply/divide busy counter that serialises HI/LO access.
- Sits beside the datapath. Its outputs drive the stall/enable/clear inputs and the Req input of every pipeline register.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- D_rs  in  5  rs index of the instruction in D
- D_rt  in  5  rt index of the instruction in D
- D_rs_tuse  in  2  cycles until D needs rs (3 = never used)
- D_rt_tuse  in  2  cycles until D needs rt (3 = never used)
- D_is_md  in  1  D instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- D_eret  in  1  D instruction is eret
- E_A3  in  5  destination register of the E instruction
- E_RegWrite  in  1  E instruction writes the GPR file
- E_tnew  in  2  cycles until the E result is ready
- M_A3  in  5  destination register of the M instruction
- M_RegWrite  in  1  M instruction writes the GPR file
- M_tnew  in  2  cycles until the M result is ready
- E_mtc0_epc  in  1  E instruction is mtc0 to EPC
- M_mtc0_epc  in  1  M instruction is mtc0 to EPC
- E_md_start  in  1  E instruction starts mult/div this cycle
- E_md_div  in  1  0 = mult type, 1 = div type (valid with E_md_start)
- exc_req  in  1  interrupt/exception request from CP0
- stall  out  1  hold PC and F/D, insert bubble into D/E
- md_busy  out  1  MD unit occupied
- Req  out  1  flush all pipeline registers, redirect to 0x00004180
- md_cnt  out  4  remaining MD busy cycles (debug)

Behaviour:
- Reset values: md_cnt=0, md_busy=0, stall=0, Req=0.
- Req:
  - Req = exc_req, combinational and same cycle.
  - When Req=1, stall is forced to 0, because flush wins over stall.
- GPR hazard (combinational):
  - Raised on rs if D_rs≠0, and (E_RegWrite & E_A3==D_rs & D_rs_tuse<E_tnew) or (M_RegWrite & M_A3==D_rs & D_rs_tuse<M_tnew).
  - Same rule applies on rt.
  - Register 0 never hazards.
- MD hazard: D_is_md & (md_busy | E_md_start).
- ERET hazard: D_eret & (E_mtc0_epc | M_mtc0_epc).
- stall = (GPR hazard | MD hazard | ERET hazard) & ~Req.
- MD counter, on posedge in priority order:
  1. reset → md_cnt=0.
  2. E_md_start & ~Req → md_cnt = E_md_div ? DIV_CYCLES : MULT_CYCLES.
  3. md_cnt≠0 → md_cnt−1.
  4. Otherwise md_cnt holds.
- md_busy = (md_cnt≠0), registered with md_cnt.
- Cycle timing: a start at edge n gives md_busy=1 from cycle n+1 through n+MULT_CYCLES (or n+DIV_CYCLES), then 0.
- E_md_start while md_busy=1 cannot occur legally, because stall blocks it. If it is applied anyway, the counter reloads.
- Req with E_md_start in the same cycle: the start is suppressed and md_cnt keeps decrementing.
- Req alone does not clear an MD operation already in progress; it runs to completion.
- Reset during a busy period clears md_cnt on that edge.
- Width: md_cnt is 4 bits. Both parameters must be ≤15; larger values are illegal.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - stall_cycles (out, 32): increments on every posedge where stall=1.
  - req_count (out, 32): increments on every posedge where Req=1.
  - Both clear to 0 on reset and wrap from 0xFFFFFFFF to 0.
- When not defined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Load-use: D_rs=5, D_rs_tuse=0, E_A3=5, E_RegWrite=1, E_tnew=2 → stall=1. With M_tnew=0 at the M stage → stall=0.
- Zero register: D_rs=0, E_A3=0, E_tnew=2, E_RegWrite=1 → stall=0.
- Mult: E_md_start=1, E_md_div=0 at cycle 0 → md_busy=1 in cycles 1–5 and 0 in cycle 6. D_is_md=1 → stall=1 in cycles 0–5.
- Div: E_md_start=1, E_md_div=1 → md_cnt=10 after the edge, counts to 0 over 10 cycles. Assert exc_req mid-way → Req=1, stall=0, md_cnt continues decrementing.
- Eret: D_eret=1, M_mtc0_epc=1 → stall=1. Assert exc_req the same cycle → stall=0, Req=1.
- Reset with md_cnt=7 → next cycle md_cnt=0, md_busy=0. With PIPE_PERF_CNT_EN, stall_cycles=0 and req_count=0.
